// File: rtl/bsg_mcl_host_pkg.sv
// Register map, FSM state encoding and packet geometry shared by the manycore-link AXI-Lite host master.
package bsg_mcl_host_pkg;

  localparam int unsigned words_per_pkt_lp = 4;
  localparam int unsigned slot_bytes_lp    = 16;

  localparam logic [31:0] tx_vacancy_off_lp = 32'h0;
  localparam logic [31:0] tx_data_off_lp    = 32'h4;
  localparam logic [31:0] rx_occupancy_off_lp = 32'h8;
  localparam logic [31:0] rx_data_off_lp    = 32'hC;

  typedef enum logic [2:0] {
    e_idle,
    e_tx_poll,
    e_tx_write,
    e_rx_poll,
    e_rx_read,
    e_rx_hold
  } host_state_e;

  function automatic logic [31:0] slot_base(input logic [31:0] base, input int unsigned slot);
    return base + 32'(slot * slot_bytes_lp);
  endfunction

endpackage

// File: rtl/bsg_mcl_axil_host_master_if.sv
// AXI-Lite bus between the host master and the manycore-link slave.
interface bsg_mcl_axil_host_master_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/bsg_mcl_axil_beat.sv
// One AXI-Lite read or write beat: request registered on start_i, done_o pulses with the B/R handshake.
// AW and W drop independently on their own handshakes; B/R ready only once the request phases are complete.
module bsg_mcl_axil_beat (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        we_i,
  input  logic        abort_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  bsg_mcl_axil_host_master_if.master axil
);

  logic        aw_pend, w_pend, b_pend, ar_pend, r_pend;
  logic [31:0] addr_r, wdata_r;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = axil.awvalid & axil.awready;
  assign w_hs  = axil.wvalid  & axil.wready;
  assign b_hs  = axil.bvalid  & axil.bready;
  assign ar_hs = axil.arvalid & axil.arready;
  assign r_hs  = axil.rvalid  & axil.rready;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      b_pend  <= 1'b0;
      ar_pend <= 1'b0;
      r_pend  <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (abort_i) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      b_pend  <= 1'b0;
      ar_pend <= 1'b0;
      r_pend  <= 1'b0;
    end else if (start_i) begin
      addr_r  <= addr_i;
      wdata_r <= wdata_i;
      aw_pend <= we_i;
      w_pend  <= we_i;
      b_pend  <= we_i;
      ar_pend <= ~we_i;
      r_pend  <= ~we_i;
    end else begin
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs)  w_pend  <= 1'b0;
      if (b_hs)  b_pend  <= 1'b0;
      if (ar_hs) ar_pend <= 1'b0;
      if (r_hs)  r_pend  <= 1'b0;
    end
  end

  assign axil.awaddr  = addr_r;
  assign axil.awvalid = aw_pend;
  assign axil.wdata   = wdata_r;
  assign axil.wstrb   = {4{w_pend}};
  assign axil.wvalid  = w_pend;
  assign axil.bready  = b_pend & ~aw_pend & ~w_pend;
  assign axil.araddr  = addr_r;
  assign axil.arvalid = ar_pend;
  assign axil.rready  = r_pend & ~ar_pend;

  assign busy_o  = aw_pend | w_pend | b_pend | ar_pend | r_pend;
  assign done_o  = b_hs | r_hs;
  assign err_o   = (b_hs & (axil.bresp != 2'b00)) | (r_hs & (axil.rresp != 2'b00));
  assign rdata_o = axil.rdata;

endmodule

// File: rtl/bsg_mcl_axil_host_master.sv
// Moves 128-bit packets between a valid/ready host port and a manycore-link AXI-Lite FIFO slot (optional watchdog: BSG_MCL_HOST_TIMEOUT_EN).
// One AXI beat in flight at a time; TX accepts a packet only after the slot reports room for a full packet, RX holds until yumi.
module bsg_mcl_axil_host_master
  import bsg_mcl_host_pkg::*;
#(
  parameter logic [31:0] axil_base_addr_p = 32'h0000_0000,
  parameter int          slot_p           = 0,
  parameter int          timeout_p        = 1024
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         tx_v_i,
  input  logic [127:0] tx_data_i,
  output logic         tx_ready_o,
  output logic         rx_v_o,
  output logic [127:0] rx_data_o,
  input  logic         rx_yumi_i,
  output logic         err_o,
  bsg_mcl_axil_host_master_if.master axil
);

  localparam logic [31:0] slot_base_lp = slot_base(axil_base_addr_p, slot_p);

  host_state_e  state_r, state_n;
  logic         prio_rx_r;
  logic [1:0]   beat_r;
  logic         tx_first_r;
  logic [127:0] tx_data_r, rx_data_r;
  logic         err_r;

  logic         beat_start, beat_we, beat_busy, beat_done, beat_err;
  logic [31:0]  beat_addr, beat_wdata, beat_rdata;
  logic         tmo;

  bsg_mcl_axil_beat beat (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (beat_start),
    .we_i    (beat_we),
    .abort_i (tmo),
    .addr_i  (beat_addr),
    .wdata_i (beat_wdata),
    .busy_o  (beat_busy),
    .done_o  (beat_done),
    .err_o   (beat_err),
    .rdata_o (beat_rdata),
    .axil    (axil)
  );

`ifdef BSG_MCL_HOST_TIMEOUT_EN
  localparam int tmo_w_lp = $clog2(timeout_p + 1);
  logic [tmo_w_lp-1:0] tmo_cnt_r;
  logic                any_hs;

  assign any_hs = (axil.awvalid & axil.awready) | (axil.wvalid & axil.wready)
                | (axil.bvalid & axil.bready)   | (axil.arvalid & axil.arready)
                | (axil.rvalid & axil.rready);
  assign tmo = beat_busy & ~any_hs & (tmo_cnt_r == tmo_w_lp'(timeout_p - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                        tmo_cnt_r <= '0;
    else if (!beat_busy || any_hs || tmo) tmo_cnt_r <= '0;
    else                                tmo_cnt_r <= tmo_cnt_r + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_n    = state_r;
    beat_start = 1'b0;
    beat_we    = 1'b0;
    beat_addr  = slot_base_lp + tx_vacancy_off_lp;
    beat_wdata = tx_data_r[{beat_r, 5'd0} +: 32];
    case (state_r)
      e_idle: state_n = (tx_v_i && !prio_rx_r) ? e_tx_poll : e_rx_poll;
      e_tx_poll: begin
        beat_start = ~beat_busy;
        if (beat_done) state_n = (beat_rdata >= 32'(words_per_pkt_lp)) ? e_tx_write : e_idle;
      end
      // The first TX_WRITE cycle is the packet handshake; beats start once the data is latched.
      e_tx_write: begin
        beat_we    = 1'b1;
        beat_addr  = slot_base_lp + tx_data_off_lp;
        beat_start = ~tx_first_r & ~beat_busy;
        if (beat_done && beat_r == 2'd3) state_n = e_idle;
      end
      e_rx_poll: begin
        beat_addr  = slot_base_lp + rx_occupancy_off_lp;
        beat_start = ~beat_busy;
        if (beat_done) state_n = (beat_rdata != 32'd0) ? e_rx_read : e_idle;
      end
      e_rx_read: begin
        beat_addr  = slot_base_lp + rx_data_off_lp;
        beat_start = ~beat_busy;
        if (beat_done && beat_r == 2'd3) state_n = e_rx_hold;
      end
      e_rx_hold: if (rx_yumi_i) state_n = e_idle;
      default:   state_n = e_idle;
    endcase
    if (tmo) begin
      state_n    = e_idle;
      beat_start = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      prio_rx_r  <= 1'b0;
      beat_r     <= 2'd0;
      tx_first_r <= 1'b0;
      tx_data_r  <= '0;
      rx_data_r  <= '0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_n;
      tx_first_r <= (state_n == e_tx_write) && (state_r != e_tx_write);
      if (beat_err || tmo) err_r <= 1'b1;
      if (tx_first_r) tx_data_r <= tx_data_i;
      // Whichever direction is picked from IDLE yields the next tie to the other one.
      if (state_r == e_idle) prio_rx_r <= (state_n == e_tx_poll);
      if (state_r == e_rx_read && beat_done) rx_data_r[{beat_r, 5'd0} +: 32] <= beat_rdata;
      if (tmo) beat_r <= 2'd0;
      else if (beat_done && (state_r == e_tx_write || state_r == e_rx_read)) beat_r <= beat_r + 2'd1;
    end
  end

  assign tx_ready_o = tx_first_r;
  assign rx_v_o     = (state_r == e_rx_hold);
  assign rx_data_o  = rx_data_r;
  assign err_o      = err_r;

endmodule

// File: tb/tb_bsg_mcl_axil_host_master.sv
// Directed bench: slot-0 instance for TX/error/timeout, slot-1 instance for RX; a select muxes which one the slave tasks talk to.
module tb_bsg_mcl_axil_host_master;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sel = 1'b0;
  logic         tx_v = 1'b0;
  logic [127:0] tx_data = '0;
  logic         rx_yumi = 1'b0;
  logic         awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]   bresp = '0, rresp = '0;
  logic [31:0]  rdata = '0;

  logic         tx_ready0, tx_ready1, rx_v0, rx_v1, err0, err1;
  logic [127:0] rx_data0, rx_data1;

  logic         tx_ready, rx_v, err, awvalid, wvalid, bready, arvalid, rready;
  logic [127:0] rx_data;
  logic [31:0]  awaddr, wdata, araddr;
  logic [3:0]   wstrb;

  int n_cmp = 0, n_err = 0, n_aw = 0, n_w = 0, n_txr = 0;

  always #5 clk = ~clk;

  bsg_mcl_axil_host_master_if ax0 ();
  bsg_mcl_axil_host_master_if ax1 ();

  assign ax0.awready = awready; assign ax1.awready = awready;
  assign ax0.wready  = wready;  assign ax1.wready  = wready;
  assign ax0.bvalid  = bvalid;  assign ax1.bvalid  = bvalid;
  assign ax0.bresp   = bresp;   assign ax1.bresp   = bresp;
  assign ax0.arready = arready; assign ax1.arready = arready;
  assign ax0.rvalid  = rvalid;  assign ax1.rvalid  = rvalid;
  assign ax0.rdata   = rdata;   assign ax1.rdata   = rdata;
  assign ax0.rresp   = rresp;   assign ax1.rresp   = rresp;

  assign awvalid  = sel ? ax1.awvalid : ax0.awvalid;
  assign awaddr   = sel ? ax1.awaddr  : ax0.awaddr;
  assign wvalid   = sel ? ax1.wvalid  : ax0.wvalid;
  assign wdata    = sel ? ax1.wdata   : ax0.wdata;
  assign wstrb    = sel ? ax1.wstrb   : ax0.wstrb;
  assign bready   = sel ? ax1.bready  : ax0.bready;
  assign arvalid  = sel ? ax1.arvalid : ax0.arvalid;
  assign araddr   = sel ? ax1.araddr  : ax0.araddr;
  assign rready   = sel ? ax1.rready  : ax0.rready;
  assign tx_ready = sel ? tx_ready1 : tx_ready0;
  assign rx_v     = sel ? rx_v1     : rx_v0;
  assign rx_data  = sel ? rx_data1  : rx_data0;
  assign err      = sel ? err1      : err0;

  bsg_mcl_axil_host_master #(.axil_base_addr_p(32'h0), .slot_p(0), .timeout_p(16)) dut0 (
    .clk_i(clk), .reset_i(rst), .tx_v_i(tx_v), .tx_data_i(tx_data), .tx_ready_o(tx_ready0),
    .rx_v_o(rx_v0), .rx_data_o(rx_data0), .rx_yumi_i(rx_yumi), .err_o(err0), .axil(ax0)
  );

  bsg_mcl_axil_host_master #(.axil_base_addr_p(32'h0), .slot_p(1)) dut1 (
    .clk_i(clk), .reset_i(rst), .tx_v_i(tx_v), .tx_data_i(tx_data), .tx_ready_o(tx_ready1),
    .rx_v_o(rx_v1), .rx_data_o(rx_data1), .rx_yumi_i(rx_yumi), .err_o(err1), .axil(ax1)
  );

  always @(posedge clk) begin
    if (awvalid && awready) n_aw++;
    if (wvalid && wready) n_w++;
    if (tx_ready) n_txr++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic s, input logic tv, input logic [127:0] td);
    @(negedge clk);
    rst = 1'b1; sel = s; tx_v = tv; tx_data = td; rx_yumi = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
    bresp = '0; rresp = '0; rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ar(input string tag);
    int n = 0;
    while (arvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk({tag, " arvalid"}, 128'(arvalid), 128'(1'b1));
  endtask

  task automatic serve_read(input string tag, input logic [31:0] exp_addr,
                            input logic [31:0] data, input logic [1:0] resp);
    int n = 0;
    wait_ar(tag);
    chk({tag, " araddr"}, 128'(araddr), 128'(exp_addr));
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rdata = data; rresp = resp;
    while (rready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    rvalid = 1'b0; rdata = '0; rresp = '0;
  endtask

  task automatic serve_write(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_data,
                             input logic [1:0] resp, input int aw_delay);
    int n = 0;
    while (awvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk({tag, " aw+w together"}, 128'({awvalid, wvalid}), 128'(2'b11));
    chk({tag, " awaddr"}, 128'(awaddr), 128'(exp_addr));
    chk({tag, " wdata"}, 128'(wdata), 128'(exp_data));
    chk({tag, " wstrb"}, 128'(wstrb), 128'(4'hF));
    wready = 1'b1;
    if (aw_delay == 0) awready = 1'b1;
    @(negedge clk);
    wready = 1'b0; awready = 1'b0;
    if (aw_delay > 0) begin
      chk({tag, " aw held, w dropped"}, 128'({awvalid, wvalid, bready}), 128'(3'b100));
      repeat (aw_delay - 1) @(negedge clk);
      awready = 1'b1;
      @(negedge clk);
      awready = 1'b0;
    end
    bvalid = 1'b1; bresp = resp;
    n = 0;
    while (bready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    bvalid = 1'b0; bresp = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int aw0, w0, txr0;
    logic hold_ok;

    // Reset state
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset outputs", 128'({tx_ready, rx_v, err, awvalid, wvalid, wstrb, bready, arvalid, rready}), 128'(0));
    chk("reset rx_data", rx_data, 128'(0));

    // TX slot 0, vacancy 8
    do_reset(1'b0, 1'b1, 128'h00000003_00000002_00000001_00000000);
    txr0 = n_txr; aw0 = n_aw;
    serve_read("tx1 poll", 32'h0, 32'd8, 2'b00);
    chk("tx1 tx_ready", 128'(tx_ready), 128'(1'b1));
    @(negedge clk); tx_v = 1'b0;
    for (int k = 0; k < 4; k++) serve_write($sformatf("tx1 w%0d", k), 32'h4, 32'(k), 2'b00, 0);
    chk("tx1 aw count", 128'(n_aw - aw0), 128'(4));
    chk("tx1 tx_ready pulses", 128'(n_txr - txr0), 128'(1));
    chk("tx1 no extra aw", 128'(awvalid), 128'(1'b0));
    serve_read("tx1 next rx poll", 32'h8, 32'd0, 2'b00);
    chk("tx1 err", 128'(err), 128'(1'b0));

    // TX vacancy 3: no writes, RX polled next, then TX retried
    do_reset(1'b0, 1'b1, 128'h1);
    txr0 = n_txr; aw0 = n_aw;
    serve_read("tx2 poll", 32'h0, 32'd3, 2'b00);
    serve_read("tx2 rx poll next", 32'h8, 32'd0, 2'b00);
    serve_read("tx2 tx poll again", 32'h0, 32'd3, 2'b00);
    tx_v = 1'b0;
    chk("tx2 no writes", 128'(n_aw - aw0), 128'(0));
    chk("tx2 no tx_ready", 128'(n_txr - txr0), 128'(0));

    // RX slot 1, occupancy 1
    do_reset(1'b1, 1'b0, 128'h0);
    serve_read("rx poll", 32'h18, 32'd1, 2'b00);
    serve_read("rx b0", 32'h1C, 32'hAAAA_0001, 2'b00);
    serve_read("rx b1", 32'h1C, 32'hBBBB_0002, 2'b00);
    serve_read("rx b2", 32'h1C, 32'hCCCC_0003, 2'b00);
    serve_read("rx b3", 32'h1C, 32'hDDDD_0004, 2'b00);
    chk("rx rx_v", 128'(rx_v), 128'(1'b1));
    chk("rx data", rx_data, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
    hold_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rx_v !== 1'b1 || rx_data !== 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001) hold_ok = 1'b0;
    end
    chk("rx held 5 cycles", 128'(hold_ok), 128'(1'b1));
    rx_yumi = 1'b1;
    @(negedge clk);
    rx_yumi = 1'b0;
    chk("rx released", 128'(rx_v), 128'(1'b0));
    serve_read("rx next poll", 32'h18, 32'd0, 2'b00);

    // awready 3 cycles after wready, vacancy exactly 4
    do_reset(1'b0, 1'b1, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
    aw0 = n_aw; w0 = n_w;
    serve_read("dly poll", 32'h0, 32'd4, 2'b00);
    @(negedge clk); tx_v = 1'b0;
    serve_write("dly w0", 32'h4, 32'hAAAA_0001, 2'b00, 3);
    serve_write("dly w1", 32'h4, 32'hBBBB_0002, 2'b00, 3);
    serve_write("dly w2", 32'h4, 32'hCCCC_0003, 2'b00, 3);
    serve_write("dly w3", 32'h4, 32'hDDDD_0004, 2'b00, 3);
    chk("dly aw count", 128'(n_aw - aw0), 128'(4));
    chk("dly w count", 128'(n_w - w0), 128'(4));
    serve_read("dly next rx poll", 32'h8, 32'd0, 2'b00);

    // SLVERR on beat 2
    do_reset(1'b0, 1'b1, 128'h44444444_33333333_22222222_11111111);
    serve_read("err poll", 32'h0, 32'd8, 2'b00);
    @(negedge clk); tx_v = 1'b0;
    serve_write("err w0", 32'h4, 32'h1111_1111, 2'b00, 0);
    chk("err clear after w0", 128'(err), 128'(1'b0));
    serve_write("err w1", 32'h4, 32'h2222_2222, 2'b10, 0);
    chk("err set after w1", 128'(err), 128'(1'b1));
    serve_write("err w2", 32'h4, 32'h3333_3333, 2'b00, 0);
    serve_write("err w3", 32'h4, 32'h4444_4444, 2'b00, 0);
    chk("err sticky", 128'(err), 128'(1'b1));

    // Reset while waiting on the RX_READ beat-2 response
    do_reset(1'b1, 1'b0, 128'h0);
    serve_read("rst poll", 32'h18, 32'd2, 2'b00);
    serve_read("rst b0", 32'h1C, 32'h1234_5678, 2'b11);
    chk("rst err before", 128'(err), 128'(1'b1));
    wait_ar("rst b1");
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("rst rready waiting", 128'(rready), 128'(1'b1));
    rst = 1'b1;
    #1;
    chk("rst outputs", 128'({tx_ready, rx_v, err, awvalid, wvalid, wstrb, bready, arvalid, rready}), 128'(0));
    chk("rst rx_data", rx_data, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    serve_read("rst first after", 32'h18, 32'd0, 2'b00);
    chk("rst no aw", 128'(awvalid), 128'(1'b0));

`ifdef BSG_MCL_HOST_TIMEOUT_EN
    // Watchdog: arready held low
    do_reset(1'b0, 1'b0, 128'h0);
    wait_ar("tmo");
    chk("tmo araddr", 128'(araddr), 128'(32'h8));
    repeat (15) @(negedge clk);
    chk("tmo err before", 128'(err), 128'(1'b0));
    @(negedge clk);
    chk("tmo fired", 128'({err, arvalid, rready}), 128'(3'b100));
    serve_read("tmo repoll", 32'h8, 32'd0, 2'b00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
